mem_ctrl: RTL

Byte-serial memory controller and arbiter for the single 8-bit RAM/IO bus. It sits between the fetch stage (instruction reads) and the memory stage (loads/stores) on one side and the mem_a/mem_dout/mem_wr pins on the other. It sequences multi-byte transfers as one-byte-per-cycle bursts, hides the 2-cycle read latency, and grants the bus to one requester at a time with data priority.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl_rdbuf.sv | 52 +++++
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-serial memory controller.
//   - FSM state encodings (IDLE, IF_RD, D_RD, D_WR)
//   - d_len request codes (LEN_B / LEN_H / LEN_W)
//   - IO window base address (reads there have side effects, e.g. UART RX)
//   - len_bytes(): d_len code to burst length in bytes
package mem_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_IF_RD = 2'd1;
   localparam logic [1:0] ST_D_RD  = 2'd2;
   localparam logic [1:0] ST_D_WR  = 2'd3;

   localparam logic [1:0] LEN_B = 2'd0;
   localparam logic [1:0] LEN_H = 2'd1;
   localparam logic [1:0] LEN_W = 2'd2;

   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   // Codes 2 and 3 both mean a full word.
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      logic [2:0] n;
      case (len)
         LEN_B:   n = 3'd1;
         LEN_H:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_ctrl_rdbuf.sv
// mem_ctrl_rdbuf: read assembly buffer for one read port.
// Tracks the byte issued on the previous cycle (pending flag + byte index) and
// drops mem_din into the matching byte lane of a 32-bit word on the cycle after issue.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        clear the assembled word (new burst granted)
//   issue_i      a read of byte idx_i is on the bus this cycle
//   idx_i        byte lane of the issued read
//   discard_i    drop the pending byte instead of capturing it
//   mem_din_i    bus read data
//   word_o       assembled word including any byte captured this cycle
module mem_ctrl_rdbuf (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        issue_i,
   input  logic [1:0]  idx_i,
   input  logic        discard_i,
   input  logic [7:0]  mem_din_i,
   output logic [31:0] word_o
);

   logic        pending_q, pending_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      pending_d = issue_i;
      idx_d     = issue_i ? idx_i : idx_q;
      word_d    = clr_i ? 32'd0 : word_q;
      // Capture ignores rdy: the byte issued last cycle is on mem_din now.
      if (pending_q && !discard_i) begin
         word_d[{idx_q, 3'b000} +: 8] = mem_din_i;
      end
   end

   // Exposing the next value lets the final byte land in rdata on the done edge.
   assign word_o = word_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         idx_q     <= 2'd0;
         word_q    <= 32'd0;
      end else begin
         pending_q <= pending_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller and arbiter for the 8-bit RAM/IO bus.
// Serves instruction fetches (IF, fixed IF_LEN bytes) and data loads/stores (D, 1/2/4
// bytes) one byte per cycle. D has priority in IDLE; a running burst is never pre-empted.
// Reads have a 2-cycle latency: address in cycle k, mem_din valid in cycle k+1.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   rdy                             global ready, low freezes the controller
//   if_req/if_addr/if_cancel        fetch request, address, abandon
//   if_done/if_rdata                fetch completion pulse and word
//   d_req/d_we/d_len/d_addr/d_wdata data request
//   d_done/d_rdata                  data completion pulse and load word
//   mem_din/mem_dout/mem_a/mem_wr   byte bus; mem_a = 0 and mem_wr = 0 when idle
// Build option: define MEMCTRL_IF_CANCEL_EN to honour if_cancel; otherwise it is ignored.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned IF_LEN     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_cancel,
   output logic                  if_done,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [1:0]            d_len,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_done,
   output logic [31:0]           d_rdata,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr
);

   logic [1:0]            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  if_done_q, if_done_d;
   logic                  d_done_q, d_done_d;
   logic [31:0]           if_rdata_q, if_rdata_d;
   logic [31:0]           d_rdata_q, d_rdata_d;

   logic                  cancel;
   logic                  rd_issue;
   logic                  if_clr, d_clr;
   logic                  if_discard;
   logic [31:0]           if_word, d_word;

`ifdef MEMCTRL_IF_CANCEL_EN
   assign cancel = if_cancel;
`else
   logic unused_if_cancel;
   assign unused_if_cancel = if_cancel;
   assign cancel           = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_done_d  = 1'b0;
      d_done_d   = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_clr     = 1'b0;
      d_clr      = 1'b0;
      rd_issue   = 1'b0;
      if_discard = 1'b0;
      mem_a      = '0;
      mem_wr     = 1'b0;
      mem_dout   = 8'd0;

      // rdy low: nothing advances and nothing is issued.
      if (rdy) begin
         unique case (state_q)
            ST_IDLE: begin
               // A requester whose done is high this cycle is still holding its old request.
               if (d_req && !d_done_q) begin
                  addr_d  = d_addr;
                  len_d   = len_bytes(d_len);
                  wdata_d = d_wdata;
                  cnt_d   = 3'd0;
                  d_clr   = 1'b1;
                  state_d = d_we ? ST_D_WR : ST_D_RD;
               end else if (if_req && !if_done_q && !cancel) begin
                  addr_d  = if_addr;
                  len_d   = 3'(IF_LEN);
                  cnt_d   = 3'd0;
                  if_clr  = 1'b1;
                  state_d = ST_IF_RD;
               end
            end
            ST_IF_RD, ST_D_RD: begin
               if (state_q == ST_IF_RD && cancel) begin
                  if_discard = 1'b1;
                  state_d    = ST_IDLE;
               end else if (cnt_q == len_q) begin
                  // All bytes issued; the last one is being captured right now.
                  state_d = ST_IDLE;
                  if (state_q == ST_IF_RD) begin
                     if_done_d  = 1'b1;
                     if_rdata_d = if_word;
                  end else begin
                     d_done_d  = 1'b1;
                     d_rdata_d = d_word;
                  end
               end else begin
                  rd_issue = 1'b1;
                  mem_a    = addr_q + ADDR_WIDTH'(cnt_q);
                  cnt_d    = cnt_q + 3'd1;
               end
            end
            ST_D_WR: begin
               mem_wr   = 1'b1;
               mem_a    = addr_q + ADDR_WIDTH'(cnt_q);
               mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
               cnt_d    = cnt_q + 3'd1;
               if (cnt_q == len_q - 3'd1) begin
                  d_done_d = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         len_q      <= 3'd0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_done_q  <= if_done_d;
         d_done_q   <= d_done_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   mem_ctrl_rdbuf u_if_buf (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (if_clr),
      .issue_i   (rd_issue && (state_q == ST_IF_RD)),
      .idx_i     (cnt_q[1:0]),
      .discard_i (if_discard),
      .mem_din_i (mem_din),
      .word_o    (if_word)
   );

   mem_ctrl_rdbuf u_d_buf (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (d_clr),
      .issue_i   (rd_issue && (state_q == ST_D_RD)),
      .idx_i     (cnt_q[1:0]),
      .discard_i (1'b0),
      .mem_din_i (mem_din),
      .word_o    (d_word)
   );

   assign if_done  = if_done_q;
   assign d_done   = d_done_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule
